// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack.
// Supports increment, jump, call (push), return (pop), stall, and sticky stack error flags.
module pc_stack #(
    parameter int             N            = 32,
    parameter int             DEPTH        = 4,
    parameter logic [N-1:0]   RESET_VECTOR = '0,
    parameter logic [N-1:0]   STEP         = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_addr,
    input  logic         call,
    input  logic [N-1:0] call_addr,
    input  logic         ret,
    input  logic         clear_err,
    output logic [N-1:0] pc,
    output logic         stack_empty,
    output logic         stack_full,
    output logic         overflow,
    output logic         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  stack [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_m1;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;
    logic [N-1:0]  pc_inc;

    assign pc_inc      = pc + STEP;
    assign count_m1    = count - CW'(1);
    assign push_idx    = count[AW-1:0];
    assign pop_idx     = count_m1[AW-1:0];
    assign stack_empty = (count == '0);
    assign stack_full  = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_VECTOR;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            // Clear first so a same-cycle error event below takes precedence.
            if (clear_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (en) begin
                if (load) begin
                    pc <= load_addr;
                end else if (call) begin
                    pc <= call_addr;
                    if (!stack_full) begin
                        stack[push_idx] <= pc_inc;
                        count           <= count + CW'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (ret) begin
                    if (!stack_empty) begin
                        pc    <= stack[pop_idx];
                        count <= count_m1;
                    end else begin
                        pc        <= pc_inc;
                        underflow <= 1'b1;
                    end
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end

endmodule

// File: doc/pc_stack.md
# pc_stack

Program counter with a hardware return-address stack for the N-bit datapath. It produces the fetch address each cycle and sits directly upstream of the muxn address-select stage: its `pc` output is one of that mux's inputs. The block supports sequential increment, absolute load (jump), call (jump plus push of the return address), return (pop), and stall. Stack overflow and underflow are recorded in sticky error flags.

## Interface
Parameters:
- `N`, 32, datapath/address width.
- `DEPTH`, 4, return-stack entries; must be ≥ 2 and a power of 2.
- `RESET_VECTOR`, 0, value of `pc` after reset; N bits.
- `STEP`, 1, increment per advance; N bits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert and active-low.
- `en` input 1: advance enable; 0 = stall, all state holds.
- `load` input 1: jump request.
- `load_addr` input N: jump target.
- `call` input 1: call request.
- `call_addr` input N: call target.
- `ret` input 1: return request.
- `clear_err` input 1: clears sticky error flags.
- `pc` output N: current fetch address (registered).
- `stack_empty` output 1: stack count == 0.
- `stack_full` output 1: stack count == DEPTH.
- `overflow` output 1: sticky; a call was made with the stack full.
- `underflow` output 1: sticky; a return was made with the stack empty.

## Operation
- State:
  - `pc` (N bits).
  - Stack array of DEPTH × N bits.
  - Count, 0..DEPTH, $clog2(DEPTH)+1 bits.
  - `overflow` and `underflow` flags.
- Reset (`rst_n`=0, async):
  - `pc` = RESET_VECTOR.
  - Count = 0 and all stack entries = 0.
  - `overflow` = 0 and `underflow` = 0.
  - Therefore `stack_empty` = 1 and `stack_full` = 0.
- With `en`=0: `pc`, stack, and count hold; requests are ignored. `clear_err` still acts.
- With `en`=1, exactly one action per cycle. Priority is load > call > ret > increment, and lower-priority requests in the same cycle are dropped.
  - Load: `pc` ← `load_addr`. Stack is unchanged.
  - Call, count < DEPTH: stack[count] ← `pc`+STEP, count+1, `pc` ← `call_addr`.
  - Call, count == DEPTH: `pc` ← `call_addr`. The push is discarded, the stack is unchanged, and `overflow` ← 1.
  - Ret, count > 0: `pc` ← stack[count-1], count−1.
  - Ret, count == 0: `pc` ← `pc`+STEP and `underflow` ← 1.
  - Otherwise: `pc` ← `pc`+STEP.
- Arithmetic: `pc`+STEP is modulo 2^N. `pc` = 2^N−1 with STEP = 1 wraps to 0, and wrap raises no flag.
- Flag updates:
  - `clear_err`=1 clears both flags on the next edge.
  - If a new overflow or underflow event occurs in the same cycle as `clear_err`, the set wins.
- Popped entries are not zeroed. Only the count defines validity.

## Timing
- Latency: every request sampled at edge k is reflected on `pc` after edge k. `pc` drives no combinational path from any input.
- `stack_full` and `stack_empty` decode the registered count. They change in the cycle after a push or pop.
- Back-to-back operations are legal at full rate:
  - Call then ret returns to call-site+STEP two edges after the call.
  - Consecutive calls fill the stack one entry per cycle.
- Reset asserted mid-operation forces reset values immediately, regardless of `clk`. Deassertion is synchronous to the design's reset synchronizer outside this block.
- Throughput: 1 action per cycle, and there are no internal wait states.

## Test plan
- Reset and increment: release `rst_n` with `en`=1 and no requests, RESET_VECTOR = 0x100.
  - Required: `pc` = 0x100, 0x101, 0x102 on successive edges, `stack_empty` = 1.
- Stall and load: hold `en`=0 for 3 cycles.
  - Required: `pc` is frozen.
  - Then `load`=1 with `load_addr`=0xDEAD0000. Required: `pc` = 0xDEAD0000 next edge.
  - Then assert `load` and `call` together. Required: the load wins and the count is unchanged.
- Nested call/return: from `pc`=0x10, call 0x200, then call 0x300, then ret, then ret.
  - Required `pc` sequence: 0x200, 0x300, 0x201, 0x11.
  - Required: count returns to 0 and `stack_empty` = 1.
- Overflow: with DEPTH = 4, make 5 calls.
  - Required: `stack_full` = 1 after the 4th, `pc` = 5th target, `overflow` = 1, and stack contents unchanged.
  - Then 4 rets return in LIFO order.
- Underflow and clear: ret with the stack empty at `pc`=0x40.
  - Required: `pc` = 0x41 and `underflow` = 1.
  - Then `clear_err` for one cycle. Required: the flag reads 0.
  - A simultaneous empty ret with `clear_err` leaves `underflow` = 1.
- Wrap and async reset: `pc` = 0xFFFFFFFF, then increment.
  - Required: `pc` = 0 with no flags.
  - Then assert `rst_n`=0 between clock edges mid-call-sequence. Required: `pc` = RESET_VECTOR and count = 0 immediately.
